// File: rtl/vlc_div_seq_if.sv
// vlc_div_seq_if: operand/result handshake bundle for the sequential divider.
// master = operand producer / result consumer, slave = divider.
interface vlc_div_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] num;
  logic [DATA_WIDTH-1:0] den;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quot;
  logic                  ovf;
  logic                  div0;

  modport master (
    output in_valid, num, den, out_ready,
    input  in_ready, out_valid, quot, ovf, div0
  );

  modport slave (
    input  in_valid, num, den, out_ready,
    output in_ready, out_valid, quot, ovf, div0
  );
endinterface

// File: rtl/vlc_div_seq.sv
// vlc_div_seq: sequential signed fixed-point divider, quot = num/den, using
// the linear-CORDIC vectoring iteration with operand range pre-scaling.
// Optional macro VLC_DIV_SAT_EN: saturate the quotient on overflow
// (default build wraps it and still flags ovf).
module vlc_div_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int CORDIC_QUAN = 16,
  parameter int N_ITER      = 18
) (
  input logic         clk,
  input logic         rst_n,
  vlc_div_seq_if.slave bus
);
  localparam int XW = DATA_WIDTH + 2;
  localparam int RW = XW + DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] SH_MAX = SW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] K_LAST = SW'(N_ITER - 1);
  localparam logic signed [XW-1:0] ONE = XW'(1) <<< CORDIC_QUAN;
  localparam logic [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [XW-1:0]   x_q, x_d;
  logic signed [XW-1:0]   y_q, y_d;
  logic signed [XW-1:0]   z_q, z_d;
  logic [SW-1:0]          sh_q, sh_d;
  logic [SW-1:0]          k_q, k_d;
  logic [DATA_WIDTH-1:0]  quot_q, quot_d;
  logic                   ovf_q, ovf_d;
  logic                   div0_q, div0_d;
  logic                   out_valid_q, out_valid_d;

  logic signed [XW-1:0]   num_ext, den_ext;
  logic signed [XW-1:0]   y_abs, x_dbl;
  logic signed [XW-1:0]   x_term, z_term;
  logic signed [XW-1:0]   y_step, z_step;
  logic signed [RW-1:0]   r_full;
  logic                   r_fits;
  logic                   term_on;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.quot      = quot_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;

  // Datapath helpers: one CORDIC step and the post-scaled result it would give.
  always_comb begin
    num_ext = {{2{bus.num[DATA_WIDTH-1]}}, bus.num};
    den_ext = {{2{bus.den[DATA_WIDTH-1]}}, bus.den};
    y_abs   = y_q[XW-1] ? -y_q : y_q;
    x_dbl   = x_q <<< 1;
    term_on = (int'(k_q) <= CORDIC_QUAN);
    x_term  = term_on ? (x_q >>> k_q) : '0;
    z_term  = term_on ? (ONE >>> k_q) : '0;
    // y==0 steps the same way as positive y
    if (y_q[XW-1]) begin
      y_step = y_q + x_term;
      z_step = z_q - z_term;
    end else begin
      y_step = y_q - x_term;
      z_step = z_q + z_term;
    end
    // Scaling back by 2^sh happens on the final z, so use the stepped value
    r_full = RW'(z_step) <<< sh_q;
    r_fits = (r_full[RW-1:DATA_WIDTH-1] == '0) || (r_full[RW-1:DATA_WIDTH-1] == '1);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      sh_q        <= '0;
      k_q         <= '0;
      quot_q      <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      sh_q        <= sh_d;
      k_q         <= k_d;
      quot_q      <= quot_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update: load, normalise, iterate, deliver.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    sh_d        = sh_q;
    k_d         = k_q;
    quot_d      = quot_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.den == '0) begin
            quot_d      = bus.num[DATA_WIDTH-1] ? Q_MIN : Q_MAX;
            ovf_d       = 1'b0;
            div0_d      = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            // Fold the divisor sign into the dividend so x is always positive
            x_d     = den_ext[XW-1] ? -den_ext : den_ext;
            y_d     = den_ext[XW-1] ? -num_ext : num_ext;
            z_d     = '0;
            sh_d    = '0;
            k_d     = '0;
            state_d = S_NORM;
          end
        end
      end

      S_NORM: begin
        // Scale x up until |y/x| < 2, the convergence range of the iteration
        if ((y_abs >= x_dbl) && (sh_q < SH_MAX)) begin
          x_d  = x_dbl;
          sh_d = sh_q + SW'(1);
        end else begin
          k_d     = '0;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        y_d = y_step;
        z_d = z_step;
        if (k_q == K_LAST) begin
          div0_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
          if (r_fits) begin
            quot_d = r_full[DATA_WIDTH-1:0];
            ovf_d  = 1'b0;
          end else begin
            ovf_d  = 1'b1;
`ifdef VLC_DIV_SAT_EN
            quot_d = r_full[RW-1] ? Q_MIN : Q_MAX;
`else
            quot_d = r_full[DATA_WIDTH-1:0];
`endif
          end
        end else begin
          k_d = k_q + SW'(1);
        end
      end

      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_vlc_div_seq.sv
// tb_vlc_div_seq: directed self-checking bench for vlc_div_seq.
module tb_vlc_div_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  vlc_div_seq_if #(.DATA_WIDTH(32)) bus ();

  vlc_div_seq #(
    .DATA_WIDTH (32),
    .CORDIC_QUAN(16),
    .N_ITER     (18)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the transfer edge.
  task automatic start_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.num      = a;
    bus.den      = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the transfer edge until out_valid is seen; bounded.
  task automatic wait_valid(input string tag, input int exp_lat);
    int cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
  endtask

  task automatic accept(input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_out_valid_low"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] q, input logic ov, input logic d0);
    start_div(tag, a, b);
    wait_valid(tag, lat);
    check({tag, "_quot"}, bus.quot, q);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(ov));
    check({tag, "_div0"}, 32'(bus.div0), 32'(d0));
    accept(tag);
  endtask

  initial begin
    logic [31:0] ovf_quot;
    bus.in_valid  = 1'b0;
    bus.num       = '0;
    bus.den       = '0;
    bus.out_ready = 1'b1;

    // Reset values, observed while reset is asserted
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quot", bus.quot, 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_div0", 32'(bus.div0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 3.0/1.5: |y|==2x takes one normalising shift (sh=1); z ends at 65537
    run_div("d3_1p5", 32'h0003_0000, 32'h0001_8000, 20, 32'h0002_0002, 1'b0, 1'b0);
    // -1.0/0.25: sh=2, z=-65535 -> -262140
    run_div("dm1_0p25", 32'hFFFF_0000, 32'h0000_4000, 21, 32'hFFFC_0004, 1'b0, 1'b0);
    // 1.0/-0.5: sh=1, z=-65535 -> -131070
    run_div("d1_m0p5", 32'h0001_0000, 32'hFFFF_8000, 20, 32'hFFFE_0002, 1'b0, 1'b0);
    // Division by zero saturates by dividend sign, one edge latency
    run_div("d5_0", 32'h0005_0000, 32'h0000_0000, 0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_div("dm5_0", 32'hFFFB_0000, 32'h0000_0000, 0, 32'h8000_0000, 1'b0, 1'b1);
    // Overflow: sh=30, z=131069; wrapped low word is 0x40000000
`ifdef VLC_DIV_SAT_EN
    ovf_quot = 32'h7FFF_FFFF;
`else
    ovf_quot = 32'h4000_0000;
`endif
    run_div("dovf", 32'h7FFF_0000, 32'h0000_0001, 49, ovf_quot, 1'b1, 1'b0);

    // Backpressure: result held, in_ready low, stray in_valid ignored
    bus.out_ready = 1'b0;
    start_div("bp", 32'h0003_0000, 32'h0001_8000);
    wait_valid("bp", 20);
    for (int i = 0; i < 10; i++) begin
      check("bp_quot_hold", bus.quot, 32'h0002_0002);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      if (i == 3) begin
        bus.num      = 32'h0005_0000;
        bus.den      = 32'h0000_0000;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("bp_div0_hold", 32'(bus.div0), 32'd0);
    bus.out_ready = 1'b1;
    accept("bp");
    repeat (2) @(negedge clk);
    check("bp_no_stray_valid", 32'(bus.out_valid), 32'd0);
    check("bp_no_stray_div0", 32'(bus.div0), 32'd0);

    // Reset in the middle of ITER aborts at once
    start_div("rstmid", 32'h0003_0000, 32'h0001_8000);
    repeat (6) @(negedge clk);
    check("rstmid_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid_quot", bus.quot, 32'd0);
    check("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_div("after_rst", 32'h0003_0000, 32'h0001_8000, 20, 32'h0002_0002, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
